hv_adc_conv_ctrl: RTL

Conversion initiator for the two HV-side analog ADCs. It periodically raises a start-of-conversion request to ADC1, then to ADC2. For each ADC it completes a four-phase handshake against that ADC's asynchronous ready line, and it flags timeouts and period overruns. It sits upstream of the ADC sampling/averaging path: that path consumes the same ready lines and the data this block causes to be produced.

---
 rtl/hv_adc_conv_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/hv_adc_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hv_adc_conv_ctrl
// Description : Periodic start-of-conversion sequencer for the two HV-side
//               ADCs. Runs a four-phase soc/rdy handshake with ADC1, then
//               ADC2, waits for the conversion period, and repeats.
//               Optional per-phase handshake timeout: HV_ADC_TMO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hv_adc_conv_ctrl #(
    parameter int PERIOD_DW = 16,
    parameter int TMO_CYC   = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_conv_en,
    input  logic [PERIOD_DW-1:0] i_period,
    input  logic                 i_ang_dgt_adc1_rdy,
    input  logic                 i_ang_dgt_adc2_rdy,
    input  logic                 i_tmo_clr,
    output logic                 o_dgt_ang_adc1_soc,
    output logic                 o_dgt_ang_adc2_soc,
    output logic                 o_adc1_done,
    output logic                 o_adc2_done,
    output logic [1:0]           o_tmo_flag,
    output logic                 o_ovr,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ1 = 3'd1,
        S_REL1 = 3'd2,
        S_REQ2 = 3'd3,
        S_REL2 = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    localparam logic [PERIOD_DW:0]   c_prd_one = 1;
    localparam logic [PERIOD_DW-1:0] c_prd_inc = 1;

    state_t               state_q, state_d;
    logic [1:0]           sync1_q, sync1_d;
    logic [1:0]           sync2_q, sync2_d;
    logic [PERIOD_DW-1:0] prd_cnt_q, prd_cnt_d;
    logic                 soc1_q, soc1_d;
    logic                 soc2_q, soc2_d;
    logic                 done1_q, done1_d;
    logic                 done2_q, done2_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    logic                 w_rdy1;
    logic                 w_rdy2;
    logic                 w_prd_hit;
    logic [1:0]           w_tmo_set;
    logic [PERIOD_DW:0]   w_cnt_p1;

    assign w_rdy1 = sync1_q[1];
    assign w_rdy2 = sync2_q[1];

    // prd_cnt >= i_period - 1, evaluated as prd_cnt + 1 >= i_period so that
    // a period of 0 or 1 is always satisfied without underflow.
    assign w_cnt_p1  = {1'b0, prd_cnt_q} + c_prd_one;
    assign w_prd_hit = (w_cnt_p1 >= {1'b0, i_period});

`ifdef HV_ADC_TMO_EN
    localparam int                c_tmo_w    = $clog2(TMO_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TMO_CYC - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_inc  = 1;

    logic [c_tmo_w-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]         tmo_flag_q, tmo_flag_d;
    logic               w_tmo_hit;

    // Phase has lasted TMO_CYC cycles; a completing handshake still wins.
    assign w_tmo_hit    = (tmo_cnt_q == c_tmo_last);
    assign w_tmo_set[0] = w_tmo_hit & (((state_q == S_REQ1) & ~w_rdy1) |
                                       ((state_q == S_REL1) &  w_rdy1));
    assign w_tmo_set[1] = w_tmo_hit & (((state_q == S_REQ2) & ~w_rdy2) |
                                       ((state_q == S_REL2) &  w_rdy2));

    // Per-phase counter restarts on each state change; sticky flags set wins over clear.
    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (!w_tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + c_tmo_inc;
        end
        tmo_flag_d = (tmo_flag_q & {2{~i_tmo_clr}}) | w_tmo_set;
    end

    // Timeout counter and sticky flag registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 2'b00;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign o_tmo_flag = tmo_flag_q;
`else
    logic [32:0] w_unused_tmo;

    assign w_tmo_set    = 2'b00;
    assign o_tmo_flag   = 2'b00;
    assign w_unused_tmo = {i_tmo_clr, 32'(TMO_CYC)};
`endif

    // Sequencer next state, period counter and registered output decodes.
    always_comb begin
        state_d = state_q;
        done1_d = 1'b0;
        done2_d = 1'b0;
        ovr_d   = 1'b0;
        sync1_d = {sync1_q[0], i_ang_dgt_adc1_rdy};
        sync2_d = {sync2_q[0], i_ang_dgt_adc2_rdy};
        case (state_q)
            S_IDLE: if (i_conv_en) state_d = S_REQ1;
            S_REQ1: begin
                if (w_rdy1)            state_d = S_REL1;
                else if (w_tmo_set[0]) state_d = i_conv_en ? S_REQ2 : S_IDLE;
            end
            S_REL1: begin
                if (!w_rdy1) begin
                    done1_d = 1'b1;
                    state_d = i_conv_en ? S_REQ2 : S_IDLE;
                end else if (w_tmo_set[0]) begin
                    state_d = i_conv_en ? S_REQ2 : S_IDLE;
                end
            end
            S_REQ2: begin
                if (w_rdy2) begin
                    state_d = S_REL2;
                end else if (w_tmo_set[1]) begin
                    state_d = i_conv_en ? S_GAP : S_IDLE;
                    ovr_d   = i_conv_en & w_prd_hit;
                end
            end
            S_REL2: begin
                if (!w_rdy2 || w_tmo_set[1]) begin
                    done2_d = ~w_rdy2;
                    state_d = i_conv_en ? S_GAP : S_IDLE;
                    ovr_d   = i_conv_en & w_prd_hit;
                end
            end
            S_GAP: begin
                if (!i_conv_en)     state_d = S_IDLE;
                else if (w_prd_hit) state_d = S_REQ1;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_REQ1) && (state_q != S_REQ1)) begin
            prd_cnt_d = '0;
        end else if (&prd_cnt_q) begin
            prd_cnt_d = prd_cnt_q;
        end else begin
            prd_cnt_d = prd_cnt_q + c_prd_inc;
        end

        soc1_d = (state_d == S_REQ1);
        soc2_d = (state_d == S_REQ2);
        busy_d = (state_d != S_IDLE);
    end

    // State, synchronizer, counter and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            prd_cnt_q <= '0;
            soc1_q    <= 1'b0;
            soc2_q    <= 1'b0;
            done1_q   <= 1'b0;
            done2_q   <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prd_cnt_q <= prd_cnt_d;
            soc1_q    <= soc1_d;
            soc2_q    <= soc2_d;
            done1_q   <= done1_d;
            done2_q   <= done2_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_dgt_ang_adc1_soc = soc1_q;
    assign o_dgt_ang_adc2_soc = soc2_q;
    assign o_adc1_done        = done1_q;
    assign o_adc2_done        = done2_q;
    assign o_ovr              = ovr_q;
    assign o_busy             = busy_q;

endmodule
`default_nettype wire
